// File: rtl/param_readback_pkg.sv
// Shared types and constants for the hierarchical parameter read-back responder.
// Optional feature macro: PARAM_READBACK_ERR_EN (flags level-0 requests via rsp_err).
package param_readback_pkg;

    // Number of nested stages in the chain (levels 1..DEPTH are valid).
    localparam int DEPTH = 3;

    // Level index carried by a request; 0 selects no stage.
    typedef logic [1:0] level_t;

    // Top-level control states.
    typedef enum logic [1:0] {
        IDLE,
        DOWN,
        UP,
        RESP
    } state_t;

endpackage

// File: rtl/param_readback_if.sv
// Request/response handshake bundle for param_readback.
// The bench drives the master side; the responder is the slave side.
interface param_readback_if #(
    parameter int WIDTH = 32
);
    import param_readback_pkg::*;

    logic             req_valid;
    logic             req_ready;
    level_t           req_level;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport master (
        output req_valid,
        output req_level,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_level,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_err
    );

endinterface

// File: rtl/param_rd_stage.sv
// One level of the read-back chain. A down-token (valid + level) is registered
// each cycle; if it names this stage, the stage launches its VALUE as an
// up-token, otherwise the down-token is offered to the next deeper stage.
// Up-tokens from deeper stages are registered and passed toward the top.
module param_rd_stage
    import param_readback_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int IDX   = 1,
    parameter int VALUE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             down_valid_in,
    input  level_t           down_level_in,
    output logic             down_valid_out,
    output level_t           down_level_out,
    input  logic             up_valid_in,
    input  logic [WIDTH-1:0] up_data_in,
    output logic             up_valid_out,
    output logic [WIDTH-1:0] up_data_out,
    output logic             hit
);

    localparam logic [WIDTH-1:0] VALUE_W = WIDTH'(VALUE);
    localparam level_t           IDX_L   = level_t'(IDX);

    logic             down_valid_reg;
    level_t           down_level_reg;
    logic             up_valid_reg;
    logic [WIDTH-1:0] up_data_reg;

    // A token addressed to this stage stops here instead of travelling deeper.
    assign hit            = down_valid_reg && (down_level_reg == IDX_L);
    assign down_valid_out = down_valid_reg && !hit;
    assign down_level_out = down_level_reg;
    assign up_valid_out   = up_valid_reg;
    assign up_data_out    = up_data_reg;

    // Down-token register: one stage of travel per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            down_valid_reg <= 1'b0;
            down_level_reg <= '0;
        end else begin
            down_valid_reg <= down_valid_in;
            down_level_reg <= down_level_in;
        end
    end

    // Up-token register: capture own VALUE on a hit, else forward the deeper token.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_valid_reg <= 1'b0;
            up_data_reg  <= '0;
        end else if (hit) begin
            up_valid_reg <= 1'b1;
            up_data_reg  <= VALUE_W;
        end else begin
            up_valid_reg <= up_valid_in;
            up_data_reg  <= up_data_in;
        end
    end

endmodule

// File: rtl/param_readback.sv
// Hierarchical parameter read-back responder. A request level walks down the
// lvl[1..DEPTH].stg chain one stage per cycle; the addressed stage returns its
// VALUE back up the chain and the top presents it as a held response.
// Optional feature macro: PARAM_READBACK_ERR_EN -- when defined, a level-0
// request answers with rsp_err=1; otherwise rsp_err is constant 0.
module param_readback
    import param_readback_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int PAR1  = 20,
    parameter int PAR2  = 30,
    parameter int PAR3  = 40
) (
    input  logic clk,
    input  logic rst_n,
    param_readback_if.slave bus
);

    state_t           state_reg;
    state_t           state_next;
    level_t           level_reg;
    logic [WIDTH-1:0] rsp_data_reg;

    logic             down_valid [0:DEPTH];
    level_t           down_level [0:DEPTH];
    logic             up_valid   [1:DEPTH+1];
    logic [WIDTH-1:0] up_data    [1:DEPTH+1];
    logic [DEPTH:1]   hit;
    logic             accept;

    assign accept = bus.req_valid && (state_reg == IDLE);

    // Inject the down-token into stage 1 on acceptance; level 0 never enters the chain.
    assign down_valid[0]     = accept && (bus.req_level != '0);
    assign down_level[0]     = bus.req_level;
    assign up_valid[DEPTH+1] = 1'b0;
    assign up_data[DEPTH+1]  = '0;

    genvar gi;
    for (gi = 1; gi <= DEPTH; gi++) begin : lvl
        param_rd_stage #(
            .WIDTH (WIDTH),
            .IDX   (gi),
            .VALUE ((gi == 1) ? PAR1 : (gi == 2) ? PAR2 : PAR3)
        ) stg (
            .clk            (clk),
            .rst_n          (rst_n),
            .down_valid_in  (down_valid[gi-1]),
            .down_level_in  (down_level[gi-1]),
            .down_valid_out (down_valid[gi]),
            .down_level_out (down_level[gi]),
            .up_valid_in    (up_valid[gi+1]),
            .up_data_in     (up_data[gi+1]),
            .up_valid_out   (up_valid[gi]),
            .up_data_out    (up_data[gi]),
            .hit            (hit[gi])
        );
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: DOWN until a stage captures, UP until the token leaves stage 1.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = DOWN;
            DOWN: begin
                if (level_reg == '0) begin
                    state_next = RESP;
                end else if (|hit) begin
                    state_next = UP;
                end
            end
            UP:   if (up_valid[1]) state_next = RESP;
            RESP: if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request level latch and response data load on entry to RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_reg    <= '0;
            rsp_data_reg <= '0;
        end else begin
            if (accept) begin
                level_reg <= bus.req_level;
            end
            if (state_reg == DOWN && level_reg == '0) begin
                rsp_data_reg <= '0;
            end else if (state_reg == UP && up_valid[1]) begin
                rsp_data_reg <= up_data[1];
            end
        end
    end

`ifdef PARAM_READBACK_ERR_EN
    logic rsp_err_reg;

    // Error flag: set for a level-0 request, cleared for any real read-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_reg <= 1'b0;
        end else if (state_reg == DOWN && level_reg == '0) begin
            rsp_err_reg <= 1'b1;
        end else if (state_reg == UP && up_valid[1]) begin
            rsp_err_reg <= 1'b0;
        end
    end

    assign bus.rsp_err = rsp_err_reg;
`else
    assign bus.rsp_err = 1'b0;
`endif

    assign bus.req_ready = (state_reg == IDLE);
    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_data  = rsp_data_reg;

endmodule

// File: tb/tb_param_readback.sv
// Self-checking bench for param_readback. Two instances run in lockstep: one
// with default parameters, one with overridden stage values. Expected data,
// error flag and latency come from a table/arithmetic reference model.
module tb_param_readback;
    import param_readback_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    param_readback_if #(.WIDTH(32)) bus0 ();
    param_readback_if #(.WIDTH(32)) bus1 ();

    param_readback #(.WIDTH(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    param_readback #(.WIDTH(32), .PAR1(8), .PAR2(80), .PAR3(400)) u_ovr (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Reference model: value per (instance, level), error flag, latency.
    int tbl [2][4] = '{'{0, 20, 30, 40}, '{0, 8, 80, 400}};

    function automatic logic [31:0] exp_data(int inst, int lvl);
        return tbl[inst][lvl];
    endfunction

    function automatic logic exp_err(int lvl);
`ifdef PARAM_READBACK_ERR_EN
        return (lvl == 0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_lat(int lvl);
        return (lvl == 0) ? 1 : 2 * lvl;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(logic v, int lvl, logic rdy);
        bus0.req_valid = v;
        bus1.req_valid = v;
        bus0.req_level = 2'(lvl);
        bus1.req_level = 2'(lvl);
        bus0.rsp_ready = rdy;
        bus1.rsp_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One read: accept, measure latency, check data, optional stall with an
    // ignored request pulse, then handshake. hold keeps req_valid asserted.
    task automatic txn(int lvl, int stall, bit hold);
        int lat;
        chk("idle_req_ready0", bus0.req_ready, 1'b1);
        chk("idle_req_ready1", bus1.req_ready, 1'b1);
        drive(1'b1, lvl, 1'b0);
        tick();
        chk("accept_req_ready0", bus0.req_ready, 1'b0);
        chk("accept_req_ready1", bus1.req_ready, 1'b0);
        if (!hold) drive(1'b0, lvl, 1'b0);
        lat = 0;
        while (!bus0.rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", lat, exp_lat(lvl));
        chk("rsp_valid1", bus1.rsp_valid, 1'b1);
        chk("rsp_data0", bus0.rsp_data, exp_data(0, lvl));
        chk("rsp_data1", bus1.rsp_data, exp_data(1, lvl));
        chk("rsp_err0", bus0.rsp_err, exp_err(lvl));
        chk("rsp_err1", bus1.rsp_err, exp_err(lvl));
        for (int s = 0; s < stall; s++) begin
            if (!hold && s == stall / 2) drive(1'b1, int'($urandom_range(0, 3)), 1'b0);
            else drive(hold, lvl, 1'b0);
            tick();
            chk("stall_rsp_valid", bus0.rsp_valid, 1'b1);
            chk("stall_req_ready", bus0.req_ready, 1'b0);
            chk("stall_rsp_data0", bus0.rsp_data, exp_data(0, lvl));
            chk("stall_rsp_data1", bus1.rsp_data, exp_data(1, lvl));
        end
        drive(hold, lvl, 1'b1);
        tick();
        chk("hs_rsp_valid0", bus0.rsp_valid, 1'b0);
        chk("hs_rsp_valid1", bus1.rsp_valid, 1'b0);
        chk("hs_req_ready0", bus0.req_ready, 1'b1);
        chk("hs_req_ready1", bus1.req_ready, 1'b1);
        drive(hold, lvl, 1'b0);
        $display("txn level=%0d stall=%0d hold=%0d latency=%0d data0=%0d data1=%0d err=%0d",
                 lvl, stall, hold, lat, exp_data(0, lvl), exp_data(1, lvl), exp_err(lvl));
    endtask

    initial begin
        drive(1'b0, 0, 1'b0);
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_req_ready", bus0.req_ready, 1'b1);
        chk("rst_rsp_valid", bus0.rsp_valid, 1'b0);
        chk("rst_rsp_data", bus0.rsp_data, 32'd0);
        chk("rst_rsp_err", bus0.rsp_err, 1'b0);
        chk("rst_rsp_valid1", bus1.rsp_valid, 1'b0);
        rst_n = 1'b1;
        tick();

        // Defaults on bus0, overrides on bus1, levels 1..3 then 3..1.
        txn(1, 0, 1'b0);
        txn(2, 0, 1'b0);
        txn(3, 0, 1'b0);
        txn(3, 0, 1'b0);
        txn(2, 0, 1'b0);
        txn(1, 0, 1'b0);

        // Backpressure with an ignored request pulse during the stall.
        txn(2, 5, 1'b0);

        // Level 0.
        txn(0, 0, 1'b0);

        // Reset mid-flight on a level-3 read.
        drive(1'b1, 3, 1'b0);
        tick();
        drive(1'b0, 3, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", bus0.rsp_valid, 1'b0);
        chk("midrst_req_ready", bus0.req_ready, 1'b1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("postrst_rsp_valid", bus0.rsp_valid, 1'b0);
            chk("postrst_rsp_valid1", bus1.rsp_valid, 1'b0);
        end
        chk("postrst_req_ready", bus0.req_ready, 1'b1);
        chk("postrst_rsp_data", bus0.rsp_data, 32'd0);
        txn(1, 0, 1'b0);

        // Back-to-back with req_valid held high.
        txn(1, 0, 1'b1);
        txn(3, 0, 1'b1);
        txn(2, 0, 1'b1);
        drive(1'b0, 0, 1'b0);
        tick();

        // Randomized reads against the reference model.
        for (int i = 0; i < 16; i++) begin
            txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
